ravenna_spi_master: RTL
=======================

# ravenna_spi_master

Synthesizable SPI initiator (mode 0, MSB first, byte transfers) that drives the SoC's `spi_csb`/`spi_sck`/`spi_sdo` pins and samples `spi_sdi`. It sits behind the CPU-side register interface and talks to external SPI responders such as the testbench flash model on the `spi_*` pins. The block provides a programmable clock divider, per-byte start/done handshaking, and chip-select hold for multi-byte commands.

## Interface
- Parameters: none. Divider width is fixed at 8 bits.
- clk  input  1  system clock
- resetn  input  1  asynchronous, active-low reset
- prescale  input  8  SCK half-period = prescale+1 clk cycles; latched at accepted start
- tx_data  input  8  byte to send; latched at accepted start
- start  input  1  single-cycle request; accepted only when busy=0
- cs_hold  input  1  level; 1 keeps CSB low after the byte completes
- busy  output  1  transfer or CSB release in progress
- done  output  1  one-cycle pulse when the byte completes
- rx_data  output  8  received byte; valid from done onward
- spi_csb  output  1  chip select, active low
- spi_sck  output  1  serial clock, idles low
- spi_sdo  output  1  initiator data out (MOSI)
- spi_sdi  input  1  responder data in (MISO)

## Operation
- Reset (async, immediate, including mid-transfer): spi_csb=1, spi_sck=0, spi_sdo=0, busy=0, done=0, rx_data=0x00, state IDLE.
- States: IDLE, XFER, HOLD, FINISH.
- IDLE: csb=1, sck=0. On start: latch tx_data and prescale, go to XFER, busy=1.
- XFER: csb=0; a 4-bit half-period count runs 0..15, with H=prescale+1 clk cycles per half-period.
  - Entering XFER: spi_sdo = bit 7, sck=0.
  - Even half-periods end with a rising edge. spi_sdi is sampled into the shift register at the same clk edge that sets sck 0→1.
  - Odd half-periods end with a falling edge, and spi_sdo shifts to the next bit on that same clk edge.
  - After the 16th half-period (8th falling edge), done pulses for one cycle and rx_data updates. Then:
    - cs_hold=1 → HOLD
    - cs_hold=0 → FINISH
- HOLD: csb=0, sck=0, busy=0, sdo holds its last value.
  - start → XFER with new byte/prescale (CSB stays low).
  - Otherwise, cs_hold=0 → FINISH.
  - start and cs_hold=0 in the same cycle: start wins.
- FINISH: busy=1, csb=0 for H cycles, then csb=1, sdo=0, busy=0, IDLE.
- start while busy=1 is ignored with no side effects.
- A prescale change after start has no effect until the next start.
- Bit order is MSB first on both directions; rx_data[7] is the first sampled bit.

## Timing
- Cycle 0 is the start cycle.
- Cycle 1: csb=0, sdo=tx[7], busy=1.
- Rising edge k (k=1..8) at cycle 1+(2k−1)H; falling edge k at cycle 1+2kH.
- done=1 in cycle 1+16H; rx_data valid in the same cycle.
- Without hold: csb=1 and busy=0 in cycle 1+17H.
- From HOLD, start at cycle n gives the first rising edge at n+1+H (same relative timing as from IDLE).
- Minimum SCK period is 2 clk cycles (prescale=0).

## Test plan
- Reset check: hold resetn low, then pulse it low mid-transfer. Required: csb=1, sck=0, sdo=0, busy=0, done=0, rx_data=0x00 immediately, asynchronous to clk.
- Single byte, prescale=0, tx=0xA5, responder returns 0x3C. Required: 8 SCK pulses of period 2; MOSI bits 1,0,1,0,0,1,0,1; done at cycle 17; rx_data=0x3C; csb high at cycle 18.
- prescale=3, tx=0xFF, responder 0x81. Required: first rising edge at cycle 5; done at cycle 65; rx_data=0x81; csb high at cycle 69.
- Two-byte command with cs_hold=1: send 0x03 then 0x5A, then drop cs_hold. Required: csb stays low across both bytes; done pulses once per byte; busy=0 in HOLD; csb rises H cycles after cs_hold falls.
- Start pulses during XFER and FINISH, plus a prescale change mid-byte. Required: ignored; current byte timing unchanged; exactly one done.
- Start with cs_hold=0 in the same HOLD cycle. Required: new byte starts and CSB never deasserts between bytes.

Source files
------------

// File: rtl/ravenna_spi_master_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : ravenna_spi_master_if
//  Description : CPU-side handshake and SPI pin bundle for ravenna_spi_master.
//                The master modport is the initiator block's view; the slave
//                modport is the view of whatever drives requests and models
//                the external responder.
//  Revision    : 1.0  initial release
// ============================================================================
interface ravenna_spi_master_if;
    logic [7:0] prescale;
    logic [7:0] tx_data;
    logic       start;
    logic       cs_hold;
    logic       busy;
    logic       done;
    logic [7:0] rx_data;
    logic       spi_csb;
    logic       spi_sck;
    logic       spi_sdo;
    logic       spi_sdi;

    modport master (
        input  prescale, tx_data, start, cs_hold, spi_sdi,
        output busy, done, rx_data, spi_csb, spi_sck, spi_sdo
    );

    modport slave (
        output prescale, tx_data, start, cs_hold, spi_sdi,
        input  busy, done, rx_data, spi_csb, spi_sck, spi_sdo
    );
endinterface
`default_nettype wire

// File: rtl/ravenna_spi_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : ravenna_spi_master
//  Description : SPI initiator, mode 0, MSB first, one byte per start.
//                Programmable SCK half-period (prescale+1 clk cycles) and
//                optional chip-select hold between bytes of one command.
//  Revision    : 1.0  initial release
// ============================================================================
module ravenna_spi_master (
    input  wire logic             clk,
    input  wire logic             resetn,
    ravenna_spi_master_if.master  bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_XFER   = 2'd1,
        S_HOLD   = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] presc_q, presc_d;   // divider latched at the accepted start
    logic [7:0] cnt_q,   cnt_d;     // clk count inside one half-period
    logic [3:0] half_q,  half_d;    // half-period index 0..15
    logic [7:0] txsh_q,  txsh_d;    // outgoing byte, current bit at [7]
    logic [7:0] rxsh_q,  rxsh_d;    // incoming bits, first sample ends in [7]
    logic [7:0] rx_q,    rx_d;
    logic       done_q,  done_d;
    logic       csb_q,   csb_d;
    logic       sck_q,   sck_d;
    logic       sdo_q,   sdo_d;

    logic       w_half_end;

    assign w_half_end = (cnt_q == presc_q);

    assign bus.busy    = (state_q == S_XFER) || (state_q == S_FINISH);
    assign bus.done    = done_q;
    assign bus.rx_data = rx_q;
    assign bus.spi_csb = csb_q;
    assign bus.spi_sck = sck_q;
    assign bus.spi_sdo = sdo_q;

    // State and datapath registers; reset forces the pins to their idle levels at once.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            presc_q <= 8'h00;
            cnt_q   <= 8'h00;
            half_q  <= 4'h0;
            txsh_q  <= 8'h00;
            rxsh_q  <= 8'h00;
            rx_q    <= 8'h00;
            done_q  <= 1'b0;
            csb_q   <= 1'b1;
            sck_q   <= 1'b0;
            sdo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            half_q  <= half_d;
            txsh_q  <= txsh_d;
            rxsh_q  <= rxsh_d;
            rx_q    <= rx_d;
            done_q  <= done_d;
            csb_q   <= csb_d;
            sck_q   <= sck_d;
            sdo_q   <= sdo_d;
        end
    end

    // Next-state and pin logic; start is only looked at in IDLE and HOLD, so it is ignored while busy.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        cnt_d   = cnt_q;
        half_d  = half_q;
        txsh_d  = txsh_q;
        rxsh_d  = rxsh_q;
        rx_d    = rx_q;
        done_d  = 1'b0;
        csb_d   = csb_q;
        sck_d   = sck_q;
        sdo_d   = sdo_q;

        case (state_q)
            S_IDLE: begin
                csb_d = 1'b1;
                sck_d = 1'b0;
                if (bus.start) begin
                    presc_d = bus.prescale;
                    txsh_d  = bus.tx_data;
                    sdo_d   = bus.tx_data[7];
                    cnt_d   = 8'h00;
                    half_d  = 4'h0;
                    csb_d   = 1'b0;
                    state_d = S_XFER;
                end
            end

            S_XFER: begin
                csb_d = 1'b0;
                if (!w_half_end) begin
                    cnt_d = cnt_q + 8'd1;
                end else begin
                    cnt_d  = 8'h00;
                    half_d = half_q + 4'd1;
                    if (!half_q[0]) begin
                        // Rising edge: responder data is captured on the same clk edge.
                        sck_d  = 1'b1;
                        rxsh_d = {rxsh_q[6:0], bus.spi_sdi};
                    end else begin
                        sck_d = 1'b0;
                        if (half_q != 4'hF) begin
                            // Falling edge: present the next bit.
                            txsh_d = {txsh_q[6:0], 1'b0};
                            sdo_d  = txsh_q[6];
                        end else begin
                            // Last falling edge: byte complete, sdo keeps bit 0.
                            done_d  = 1'b1;
                            rx_d    = rxsh_q;
                            state_d = bus.cs_hold ? S_HOLD : S_FINISH;
                        end
                    end
                end
            end

            S_HOLD: begin
                csb_d = 1'b0;
                sck_d = 1'b0;
                if (bus.start) begin
                    presc_d = bus.prescale;
                    txsh_d  = bus.tx_data;
                    sdo_d   = bus.tx_data[7];
                    cnt_d   = 8'h00;
                    half_d  = 4'h0;
                    state_d = S_XFER;
                end else if (!bus.cs_hold) begin
                    cnt_d   = 8'h00;
                    state_d = S_FINISH;
                end
            end

            S_FINISH: begin
                sck_d = 1'b0;
                if (w_half_end) begin
                    cnt_d   = 8'h00;
                    csb_d   = 1'b1;
                    sdo_d   = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
